// File: rtl/mmu_pkg.sv
// mmu_pkg: shared TLB entry/command types and segment constants for mmu_tlb
package mmu_pkg;
  localparam int ASID_MAX = 8;
  localparam logic [3:0] KSEG0_HI = 4'h8;
  localparam logic [3:0] KSEG1_HI = 4'hA;
  localparam logic [31:0] PA_MASK = 32'h1FFF_FFFF;
  localparam logic [2:0] C_UNCACHED = 3'd2;
  typedef enum logic [1:0] {CMD_NONE, CMD_WRITE, CMD_READ, CMD_PROBE} tlb_cmd_e;
  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    logic        g;
  } tlb_lo_t;
  typedef struct packed {
    logic [18:0]         vpn2;
    logic [ASID_MAX-1:0] asid;
    tlb_lo_t             lo1;
    tlb_lo_t             lo0;
  } tlb_entry_t;
  typedef struct packed {
    logic [31:0] paddr;
    logic        uncached;
    logic        refill;
    logic        invalid;
    logic        modified;
  } lk_res_t;
  function automatic logic in_seg(logic [31:0] va, logic [3:0] hi);
    return va[31:29] == hi[3:1];
  endfunction
endpackage

// File: rtl/mmu_tlb_if.sv
// mmu_tlb_if: lookup ports, CP0 command bus and results of mmu_tlb
interface mmu_tlb_if import mmu_pkg::*; #(
  parameter int NUM_PORTS   = 2,
  parameter int ASID_W      = 8,
  parameter int TLB_ENTRIES = 16
) ();
  localparam int IDX_W = $clog2(TLB_ENTRIES);
  logic [NUM_PORTS-1:0]       lk_req_i;
  logic [NUM_PORTS-1:0][31:0] lk_vaddr_i;
  logic [NUM_PORTS-1:0]       lk_store_i;
  logic [NUM_PORTS-1:0]       lk_valid_o;
  logic [NUM_PORTS-1:0][31:0] lk_paddr_o;
  logic [NUM_PORTS-1:0]       lk_uncached_o;
  logic [NUM_PORTS-1:0]       lk_refill_o;
  logic [NUM_PORTS-1:0]       lk_invalid_o;
  logic [NUM_PORTS-1:0]       lk_modified_o;
  logic [ASID_W-1:0]          cp0_asid_i;
  tlb_cmd_e                   cmd_i;
  logic [IDX_W-1:0]           cmd_index_i;
  tlb_entry_t                 cmd_entry_i;
  logic                       cmd_done_o;
  tlb_entry_t                 cmd_entry_o;
  logic                       probe_hit_o;
  logic [IDX_W-1:0]           probe_index_o;
  modport slave (
    input  lk_req_i, lk_vaddr_i, lk_store_i, cp0_asid_i, cmd_i, cmd_index_i, cmd_entry_i,
    output lk_valid_o, lk_paddr_o, lk_uncached_o, lk_refill_o, lk_invalid_o, lk_modified_o,
           cmd_done_o, cmd_entry_o, probe_hit_o, probe_index_o
  );
  modport master (
    output lk_req_i, lk_vaddr_i, lk_store_i, cp0_asid_i, cmd_i, cmd_index_i, cmd_entry_i,
    input  lk_valid_o, lk_paddr_o, lk_uncached_o, lk_refill_o, lk_invalid_o, lk_modified_o,
           cmd_done_o, cmd_entry_o, probe_hit_o, probe_index_o
  );
endinterface

// File: rtl/tlb_match.sv
// tlb_match: associative VPN2/ASID compare over all entries, lowest index wins
module tlb_match import mmu_pkg::*; #(
  parameter int N      = 16,
  parameter int ASID_W = 8,
  parameter int IDX_W  = $clog2(N)
) (
  input  tlb_entry_t        ent_i [N],
  input  logic [18:0]       vpn2_i,
  input  logic [ASID_W-1:0] asid_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o,
  output tlb_entry_t        ent_o
);
  // scan downwards so the lowest matching index is the last one written
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    ent_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ent_i[i].vpn2 == vpn2_i && (ent_i[i].lo0.g || ent_i[i].asid[ASID_W-1:0] == asid_i)) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
        ent_o = ent_i[i];
      end
    end
  end
endmodule

// File: rtl/mmu_tlb.sv
// mmu_tlb: MIPS32 joint-TLB MMU; MMU_TLB_EN enables the TLB, otherwise mapped segments pass through
module mmu_tlb import mmu_pkg::*; #(
  parameter int TLB_ENTRIES = 16,
  parameter int NUM_PORTS   = 2,
  parameter int ASID_W      = 8
) (
  input logic       clk,
  input logic       resetn,
  mmu_tlb_if.slave  bus
);
  localparam int IDX_W = $clog2(TLB_ENTRIES);
  logic done_q;
  // every command completes in one cycle
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) done_q <= 1'b0;
    else done_q <= bus.cmd_i != CMD_NONE;
  assign bus.cmd_done_o = done_q;
`ifdef MMU_TLB_EN
  tlb_entry_t tlb_q [TLB_ENTRIES];
  tlb_entry_t rd_q, wr_ent, unused_pent;
  logic phit, phit_q;
  logic [IDX_W-1:0] pidx, pidx_q;
  tlb_match #(.N(TLB_ENTRIES), .ASID_W(ASID_W), .IDX_W(IDX_W)) u_probe (
    .ent_i(tlb_q), .vpn2_i(bus.cmd_entry_i.vpn2), .asid_i(bus.cp0_asid_i),
    .hit_o(phit), .idx_o(pidx), .ent_o(unused_pent)
  );
  // the global bit is the AND of both EntryLo G bits, kept identical in both halves
  always_comb begin
    wr_ent = bus.cmd_entry_i;
    wr_ent.lo0.g = bus.cmd_entry_i.lo0.g & bus.cmd_entry_i.lo1.g;
    wr_ent.lo1.g = bus.cmd_entry_i.lo0.g & bus.cmd_entry_i.lo1.g;
  end
  // entry storage plus read/probe result registers held until the next such command
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < TLB_ENTRIES; i++) tlb_q[i] <= '0;
      rd_q <= '0;
      phit_q <= 1'b0;
      pidx_q <= '0;
    end else begin
      if (bus.cmd_i == CMD_WRITE) tlb_q[bus.cmd_index_i] <= wr_ent;
      if (bus.cmd_i == CMD_READ) rd_q <= tlb_q[bus.cmd_index_i];
      if (bus.cmd_i == CMD_PROBE) begin
        phit_q <= phit;
        pidx_q <= pidx;
      end
    end
  assign bus.cmd_entry_o = rd_q;
  assign bus.probe_hit_o = phit_q;
  assign bus.probe_index_o = pidx_q;
`else
  logic unused_ok;
  assign unused_ok = ^{bus.cp0_asid_i, bus.cmd_index_i, bus.cmd_entry_i, bus.lk_store_i};
  assign bus.cmd_entry_o = '0;
  assign bus.probe_hit_o = 1'b0;
  assign bus.probe_index_o = '0;
`endif
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [31:0] va;
    logic k0, k1, unm, vld_q;
    lk_res_t res_d, res_q;
    assign va = bus.lk_vaddr_i[p];
    assign k0 = in_seg(va, KSEG0_HI);
    assign k1 = in_seg(va, KSEG1_HI);
    assign unm = k0 | k1;
`ifdef MMU_TLB_EN
    logic hit;
    logic [IDX_W-1:0] unused_idx;
    tlb_entry_t ent;
    tlb_lo_t lo;
    tlb_match #(.N(TLB_ENTRIES), .ASID_W(ASID_W), .IDX_W(IDX_W)) u_match (
      .ent_i(tlb_q), .vpn2_i(va[31:13]), .asid_i(bus.cp0_asid_i),
      .hit_o(hit), .idx_o(unused_idx), .ent_o(ent)
    );
    assign lo = va[12] ? ent.lo1 : ent.lo0;
    assign res_d = '{
      paddr:    unm ? va & PA_MASK : {lo.pfn, va[11:0]},
      uncached: k1 | (!unm & lo.c == C_UNCACHED),
      refill:   !unm & !hit,
      invalid:  !unm & hit & !lo.v,
      modified: !unm & hit & lo.v & !lo.d & bus.lk_store_i[p]
    };
`else
    assign res_d = '{paddr: unm ? va & PA_MASK : va, uncached: k1, refill: 1'b0, invalid: 1'b0, modified: 1'b0};
`endif
    // registered result, held while no request is presented
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
        vld_q <= 1'b0;
        res_q <= '0;
      end else begin
        vld_q <= bus.lk_req_i[p];
        if (bus.lk_req_i[p]) res_q <= res_d;
      end
    assign bus.lk_valid_o[p] = vld_q;
    assign bus.lk_paddr_o[p] = res_q.paddr;
    assign bus.lk_uncached_o[p] = res_q.uncached;
    assign bus.lk_refill_o[p] = res_q.refill;
    assign bus.lk_invalid_o[p] = res_q.invalid;
    assign bus.lk_modified_o[p] = res_q.modified;
  end
endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: scoreboard bench for mmu_tlb lookups and CP0 commands
module tb_mmu_tlb;
  import mmu_pkg::*;
  localparam int N = 16;
  localparam int P = 2;
  localparam int AW = 8;
  typedef struct packed {logic [31:0] pa; logic unc, rf, inv, mod;} exp_t;
  typedef struct packed {tlb_cmd_e cmd; tlb_entry_t ent; logic hit; logic [3:0] idx;} cexp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int errors = 0;
  int checks = 0;
  exp_t lkq [P][$];
  cexp_t cq [$];
  tlb_entry_t mtlb [N];
  logic pend [P];
  logic cpend, wr_pend;
  logic [3:0] wr_idx;
  tlb_entry_t wr_ent;
  logic [31:0] vas [6] = '{32'h9FC0_0100, 32'hBFAF_0000, 32'h0040_1ABC, 32'h0040_0000, 32'h7000_0000, 32'h8000_1234};
  always #5 clk = ~clk;
  mmu_tlb_if #(.NUM_PORTS(P), .ASID_W(AW), .TLB_ENTRIES(N)) bus ();
  mmu_tlb #(.TLB_ENTRIES(N), .NUM_PORTS(P), .ASID_W(AW)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(logic [31:0] va, logic st, logic [7:0] asid);
    exp_t e;
    logic [2:0] s;
    e = '0;
    s = va[31:29];
    if (s == 3'b100 || s == 3'b101) begin
      e.pa = va & 32'h1FFF_FFFF;
      e.unc = s == 3'b101;
    end else begin
`ifdef MMU_TLB_EN
      int hi;
      tlb_lo_t lo;
      hi = -1;
      for (int i = N - 1; i >= 0; i--)
        if (mtlb[i].vpn2 == va[31:13] && (mtlb[i].lo0.g || mtlb[i].asid == asid)) hi = i;
      if (hi < 0) e.rf = 1'b1;
      else begin
        lo = va[12] ? mtlb[hi].lo1 : mtlb[hi].lo0;
        if (!lo.v) e.inv = 1'b1;
        else if (st && !lo.d) e.mod = 1'b1;
        else begin
          e.pa = {lo.pfn, va[11:0]};
          e.unc = lo.c == 3'd2;
        end
      end
`else
      e.pa = va;
`endif
    end
    return e;
  endfunction
  function automatic tlb_entry_t mk(logic [18:0] vpn2, logic [7:0] asid, logic g, logic [19:0] pfn1,
                                    logic [2:0] c1, logic d1, logic v1, logic v0);
    tlb_entry_t t;
    t = '0;
    t.vpn2 = vpn2;
    t.asid = asid;
    t.lo0 = '{pfn: 20'h0ABCD, c: 3'd3, d: 1'b1, v: v0, g: g};
    t.lo1 = '{pfn: pfn1, c: c1, d: d1, v: v1, g: g};
    return t;
  endfunction
  task automatic lookup(int p, logic [31:0] va, logic st);
    bus.lk_req_i[p] = 1'b1;
    bus.lk_vaddr_i[p] = va;
    bus.lk_store_i[p] = st;
    lkq[p].push_back(model(va, st, bus.cp0_asid_i));
    pend[p] = 1'b1;
  endtask
  task automatic command(tlb_cmd_e c, logic [3:0] idx, tlb_entry_t ent);
    cexp_t e;
    e = '0;
    e.cmd = c;
    bus.cmd_i = c;
    bus.cmd_index_i = idx;
    bus.cmd_entry_i = ent;
    cpend = 1'b1;
`ifdef MMU_TLB_EN
    if (c == CMD_READ) e.ent = mtlb[idx];
    if (c == CMD_PROBE)
      for (int i = N - 1; i >= 0; i--)
        if (mtlb[i].vpn2 == ent.vpn2 && (mtlb[i].lo0.g || mtlb[i].asid == bus.cp0_asid_i)) begin
          e.hit = 1'b1;
          e.idx = 4'(i);
        end
    if (c == CMD_WRITE) begin
      wr_pend = 1'b1;
      wr_idx = idx;
      wr_ent = ent;
      wr_ent.lo0.g = ent.lo0.g & ent.lo1.g;
      wr_ent.lo1.g = ent.lo0.g & ent.lo1.g;
    end
`endif
    cq.push_back(e);
  endtask
  task automatic cycle();
    exp_t e;
    cexp_t c;
    @(posedge clk);
    if (wr_pend) mtlb[wr_idx] = wr_ent;
    wr_pend = 1'b0;
    #1;
    for (int p = 0; p < P; p++) begin
      check($sformatf("valid%0d", p), 128'(bus.lk_valid_o[p]), 128'(pend[p]));
      if (pend[p] && lkq[p].size() > 0) begin
        e = lkq[p].pop_front();
        check($sformatf("refill%0d", p), 128'(bus.lk_refill_o[p]), 128'(e.rf));
        check($sformatf("invalid%0d", p), 128'(bus.lk_invalid_o[p]), 128'(e.inv));
        check($sformatf("modified%0d", p), 128'(bus.lk_modified_o[p]), 128'(e.mod));
        if (!(e.rf || e.inv || e.mod)) begin
          check($sformatf("paddr%0d", p), 128'(bus.lk_paddr_o[p]), 128'(e.pa));
          check($sformatf("uncached%0d", p), 128'(bus.lk_uncached_o[p]), 128'(e.unc));
        end
      end
      pend[p] = 1'b0;
      bus.lk_req_i[p] = 1'b0;
      bus.lk_store_i[p] = 1'b0;
    end
    check("cmd_done", 128'(bus.cmd_done_o), 128'(cpend));
    if (cpend && cq.size() > 0) begin
      c = cq.pop_front();
      if (c.cmd == CMD_READ) check("read_entry", 128'(bus.cmd_entry_o), 128'(c.ent));
      if (c.cmd == CMD_PROBE) begin
        check("probe_hit", 128'(bus.probe_hit_o), 128'(c.hit));
        check("probe_index", 128'(bus.probe_index_o), 128'(c.idx));
      end
    end
    cpend = 1'b0;
    bus.cmd_i = CMD_NONE;
  endtask
  initial begin
    bus.lk_req_i = '0;
    bus.lk_vaddr_i = '0;
    bus.lk_store_i = '0;
    bus.cp0_asid_i = '0;
    bus.cmd_i = CMD_NONE;
    bus.cmd_index_i = '0;
    bus.cmd_entry_i = '0;
    for (int i = 0; i < N; i++) mtlb[i] = '0;
    for (int p = 0; p < P; p++) pend[p] = 1'b0;
    cpend = 1'b0;
    wr_pend = 1'b0;
    wr_idx = '0;
    wr_ent = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 128'(bus.lk_valid_o), 128'(0));
    check("rst_done", 128'(bus.cmd_done_o), 128'(0));
    check("rst_paddr", 128'(bus.lk_paddr_o), 128'(0));
    check("rst_flags", 128'({bus.lk_refill_o, bus.lk_invalid_o, bus.lk_modified_o, bus.lk_uncached_o}), 128'(0));
    check("rst_entry", 128'(bus.cmd_entry_o), 128'(0));
    check("rst_probe", 128'({bus.probe_hit_o, bus.probe_index_o}), 128'(0));
    resetn = 1'b1;
    lookup(0, 32'h9FC0_0100, 1'b0);
    lookup(1, 32'hBFAF_0000, 1'b0);
    cycle();
    lookup(0, 32'hBFAF_0000, 1'b0);
    cycle();
    bus.cp0_asid_i = 8'd5;
    command(CMD_WRITE, 4'd3, mk(19'h00200, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b0, 1'b1, 1'b0));
    cycle();
    lookup(0, 32'h0040_1ABC, 1'b0);
    cycle();
    lookup(0, 32'h0040_1ABC, 1'b1);
    cycle();
    bus.cp0_asid_i = 8'd6;
    lookup(0, 32'h0040_1ABC, 1'b0);
    cycle();
    command(CMD_WRITE, 4'd3, mk(19'h00200, 8'd5, 1'b1, 20'h12345, 3'd2, 1'b1, 1'b1, 1'b0));
    cycle();
    lookup(0, 32'h0040_1ABC, 1'b0);
    lookup(1, 32'h0040_0000, 1'b0);
    cycle();
    command(CMD_PROBE, 4'd0, mk(19'h00200, 8'd0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 1'b0));
    cycle();
    command(CMD_PROBE, 4'd0, mk(19'h38000, 8'd0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 1'b0));
    cycle();
    command(CMD_READ, 4'd3, '0);
    cycle();
    command(CMD_WRITE, 4'd3, mk(19'h00200, 8'd5, 1'b1, 20'h54321, 3'd3, 1'b1, 1'b1, 1'b1));
    lookup(0, 32'h0040_1ABC, 1'b0);
    cycle();
    lookup(0, 32'h0040_1ABC, 1'b0);
    lookup(1, 32'h0040_0000, 1'b1);
    cycle();
    for (int k = 0; k < 24; k++) begin
      bus.cp0_asid_i = 8'($urandom_range(4, 6));
      for (int p = 0; p < P; p++)
        if ($urandom_range(0, 3) != 0) lookup(p, vas[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
      if (k % 6 == 5) command(CMD_READ, 4'($urandom_range(2, 4)), '0);
      cycle();
    end
    lookup(0, 32'h9FC0_0000, 1'b0);
    command(CMD_READ, 4'd3, '0);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_valid", 128'(bus.lk_valid_o[0]), 128'(0));
    check("rst_mid_done", 128'(bus.cmd_done_o), 128'(0));
    lkq[0].delete();
    cq.delete();
    pend[0] = 1'b0;
    cpend = 1'b0;
    bus.lk_req_i = '0;
    bus.cmd_i = CMD_NONE;
    for (int i = 0; i < N; i++) mtlb[i] = '0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    lookup(0, 32'h0040_1ABC, 1'b0);
    cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mmu_tlb.md
# mmu_tlb

Parametrised MIPS32 memory-management unit replacing the fixed kseg0/kseg1 address mapper between the fetch/memory stages and the cache/AXI path. It holds a fully associative joint TLB of `TLB_ENTRIES` dual-page entries and serves `NUM_PORTS` registered lookup ports (port 0 = instruction, port 1 = data). It executes CP0 TLBWI/TLBWR/TLBR/TLBP commands and reports refill/invalid/modified exceptions.

## Interface
Parameters:
- `TLB_ENTRIES`, 16: entry count, power of two, 4..32.
- `NUM_PORTS`, 2: independent lookup ports.
- `ASID_W`, 8: ASID width.

Ports:
- `clk` in 1: the single clock; all state on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `lk_req_i[p]` in 1: lookup request, port p.
- `lk_vaddr_i[p]` in 32: virtual address.
- `lk_store_i[p]` in 1: access is a store.
- `lk_valid_o[p]` out 1: result valid, one cycle after `lk_req_i`.
- `lk_paddr_o[p]` out 32: physical address.
- `lk_uncached_o[p]` out 1: uncached access.
- `lk_refill_o[p]`, `lk_invalid_o[p]`, `lk_modified_o[p]` out 1 each: exception flags.
- `cp0_asid_i` in `ASID_W`: current EntryHi.ASID.
- `cmd_i` in 2: 0 none, 1 write, 2 read, 3 probe.
- `cmd_index_i` in log2(`TLB_ENTRIES`): Index or Random value.
- `cmd_entry_i` in entry: EntryHi/EntryLo0/EntryLo1 fields for write.
- `cmd_done_o` out 1: command complete.
- `cmd_entry_o` out entry: read data.
- `probe_hit_o` out 1: probe matched.
- `probe_index_o` out log2(`TLB_ENTRIES`): matching index.

## Operation
- Entry: VPN2[31:13], ASID, G, and per even/odd page PFN[19:0], C[2:0], D, V. Page size fixed 4 KB; VA[12] selects odd page.
- Segment decode on VA[31:28]: 8/9 (kseg0) unmapped, PA = VA & 0x1FFFFFFF, cached. A/B (kseg1) unmapped, same PA, uncached. All others mapped.
- Mapped hit: VPN2 equal and (G or ASID equal). PA = {PFN, VA[11:0]}; uncached when C == 2.
- Multiple hits: lowest index wins; software must not create them.
- No hit: refill = 1. Hit with V = 0: invalid = 1. Store hit with V = 1, D = 0: modified = 1. Flags are mutually exclusive; PA is don't-care when any flag is set.
- Write: entry[`cmd_index_i`] ← `cmd_entry_i`; G stored as G0 & G1.
- Read: `cmd_entry_o` ← entry[`cmd_index_i`].
- Probe: compare EntryHi (VPN2, `cp0_asid_i`) against all entries. Sets `probe_hit_o` and `probe_index_o`; index is 0 on miss.

## Timing
- Reset: all entries V0 = V1 = G = 0, others 0. All outputs 0.
- Lookup latency 1 cycle, fully pipelined; one new request per port per cycle. `lk_valid_o` is a registered copy of `lk_req_i`. Result registers hold their value while `lk_req_i` = 0.
- Commands take 1 cycle: `cmd_done_o` pulses the cycle after `cmd_i` ≠ 0. Outputs of read and probe are valid with `cmd_done_o` and held until the next command.
- Write concurrent with a lookup or probe: the lookup/probe sees old contents; the new entry is visible from the next cycle.
- `cp0_asid_i` is sampled at request time.
- Reset asserted mid-operation: in-flight results are dropped, `lk_valid_o` and `cmd_done_o` go to 0 immediately.

## Configuration
- `MMU_TLB_EN` defined: behaviour as above.
- `MMU_TLB_EN` undefined:
  - No entry storage.
  - Mapped segments pass through identity (PA = VA, cached); exception flags are tied 0.
  - Commands still pulse `cmd_done_o`; `cmd_entry_o`, `probe_hit_o` and `probe_index_o` read 0.
  - Lookup latency stays 1 cycle.

## Structure
- Package `mmu_pkg` holds:
  - the `tlb_entry_t` struct;
  - the `tlb_cmd_e` encoding;
  - segment constants (`KSEG0_HI = 4'h8`, `KSEG1_HI = 4'hA`, `PA_MASK = 32'h1FFF_FFFF`);
  - the uncached C value 2.
- One sub-module, `tlb_match`: combinational associative compare of one VPN2/ASID against all entries. Outputs hit, lowest index and the selected entry. It is instantiated once per port plus once for probe.

## Test plan
- Reset, port 0 lookup of 0x9FC0_0100 → next cycle paddr 0x1FC0_0100, uncached 0. Lookup of 0xBFAF_0000 → paddr 0x1FAF_0000, uncached 1.
- Write index 3: VPN2 = 0x00400>>1, ASID 5, PFN1 = 0x12345, V1 = 1, D1 = 0, C1 = 3. Then with ASID 5, load 0x0040_1ABC → paddr 0x1234_5ABC, no flags. Store to the same address → modified 1.
- Same lookup with ASID 6 and G = 0 → refill 1. After rewriting index 3 with G = 1 → hit.
- Even page of index 3 with V0 = 0: lookup 0x0040_0000 → invalid 1. Probe with EntryHi VPN2 0x00200 → hit 1, index 3. Probe 0x7000_0000 → hit 0.
- Write to index 3 and lookup of the same VA in the same cycle → old result. Next-cycle lookup → new result. Reset asserted the cycle after a request → `lk_valid_o` = 0.
- With `MMU_TLB_EN` undefined: lookup 0x0040_1ABC → paddr 0x0040_1ABC, no flags. Read command → `cmd_done_o` pulses, `cmd_entry_o` = 0.
